serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
Serial-in, parallel-out receiver for the LSB-first bitstream produced by the team's parallel-load shift-register transmitter. Samples one bit per qualified clock, assembles DATA_WIDTH-bit words and presents each word on a valid/ready output holding register. Flags overrun when a new word completes while the previous word is still unaccepted. Sits at the receive end of the serial link, feeding word-oriented logic.

Parameters:
DATA_WIDTH, 16, word width in bits; must be >= 2

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
din  input  1  serial data bit, LSB of the word first
din_en  input  1  din is valid this cycle; sampled only when high
sync_clr  input  1  synchronous flush of the partial word and bit counter
dout  output  DATA_WIDTH  assembled word
dout_valid  output  1  dout holds an unaccepted word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
overrun  output  1  one-cycle pulse: a completed word was dropped
parity_err  output  1  parity result for the word on dout (see Optional Feature)

Behaviour:
- Reset (resetn low, asynchronous): shifter=0, bit_cnt=0, state=COLLECT, dout=0, dout_valid=0, overrun=0, parity_err=0. Reset mid-word discards the partial word.
- Shifter: on din_en, shifter <= {din, shifter[DATA_WIDTH-1:1]}. The first bit received lands in dout[0].
- bit_cnt: width $clog2(DATA_WIDTH). Increments on each din_en. Wraps to 0 after DATA_WIDTH-1.
- Word completion: din_en && bit_cnt==DATA_WIDTH-1 (state COLLECT). The completed word is {din, shifter[DATA_WIDTH-1:1]}. Cycles with din_en low do not advance anything; gaps between bits are allowed.
- Latency: dout/dout_valid update on the clock edge that samples the last bit and are visible the following cycle.
- Output register:
  - On completion, if dout_valid==0 or dout_ready==1, load dout and set dout_valid=1.
  - Simultaneous accept + completion: the old word is consumed, the new word is loaded, and dout_valid stays 1.
  - If dout_valid==1 and dout_ready==0 at completion: drop the new word, keep dout unchanged, and assert overrun for exactly one cycle.
  - Accept without completion: dout_valid <= 0. dout holds its last value.
- dout is stable while dout_valid && !dout_ready.
- sync_clr: clears shifter and bit_cnt, and forces state=COLLECT. It has priority over din_en in the same cycle. It does not affect dout, dout_valid or the pending handshake.
- FSM states:
  - COLLECT: data bits are received here.
  - PARITY: exists only with the macro. Entered after the last data bit instead of completing; the next din_en bit is the parity bit, then completion occurs and the FSM returns to COLLECT.

Optional Feature:
Macro: SERIAL_DESERIALIZER_PARITY_EN
- With the macro defined:
  - Each frame is DATA_WIDTH data bits followed by one even-parity bit.
  - The word completes on the parity bit, not the last data bit.
  - parity_err is loaded with dout: 1 if the XOR of the data bits and the parity bit is 1.
  - The word is delivered regardless of parity_err.
  - Overrun drops the word and its parity_err together.
- Without the macro:
  - No PARITY state.
  - parity_err is tied to 0.

Decomposition:
- Package serial_deserializer_pkg holds:
  - the typedef enum logic state_t {COLLECT, PARITY}
  - a function computing bit-counter width
- One sub-module, deser_out_reg: the valid/ready holding register with overrun detection. Parameterised by DATA_WIDTH and carrying a 1-bit sideband for parity_err.

Test Plan:
- DATA_WIDTH=16, reset, then 16 consecutive din_en bits of 0xA5C3 LSB-first, dout_ready=1 -> dout=0xA5C3 and dout_valid=1 one cycle after the 16th bit; dout_valid=0 the next cycle.
- Same word with random din_en gaps of 0-3 cycles -> identical dout=0xA5C3; no change while din_en is low.
- dout_ready=0: send 0x1234, then 0xFFFF -> dout stays 0x1234, overrun pulses for 1 cycle at the 0xFFFF completion; raising dout_ready clears dout_valid.
- Word 0x0001 pending; complete 0x8000 in the same cycle as dout_ready=1 -> dout=0x8000, dout_valid stays 1, no overrun.
- After 7 bits assert sync_clr with din_en=1, then send 0x00FF -> dout=0x00FF. Repeat with resetn dropped mid-word -> all outputs 0 immediately.
- With SERIAL_DESERIALIZER_PARITY_EN: 0x0003 plus parity bit 0 -> parity_err=0; 0x0007 plus parity bit 0 -> parity_err=1, dout=0x0007.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_deserializer_pkg
//   Shared types and helpers for the serial deserializer block.
//   - state_t     : receive FSM states (PARITY only reachable when the
//                   SERIAL_DESERIALIZER_PARITY_EN macro is defined)
//   - cnt_width() : width of the bit counter for a given word width
// -----------------------------------------------------------------------------
package serial_deserializer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,  // receiving data bits
    PARITY  = 1'b1   // waiting for the trailing even-parity bit
  } state_t;

  // Bit counter width: enough to index DATA_WIDTH bits, never below 1.
  function automatic int cnt_width(input int data_width);
    return (data_width <= 2) ? 1 : $clog2(data_width);
  endfunction

endpackage : serial_deserializer_pkg

// File: rtl/deser_out_reg.sv
// -----------------------------------------------------------------------------
// deser_out_reg
//   Valid/ready output holding register for the deserializer, with a 1-bit
//   sideband that travels with each word and overrun detection.
//
//   Ports:
//     clk, resetn  : clock, asynchronous active-low reset
//     load_i       : a new word has completed this cycle
//     data_i       : the completed word
//     side_i       : sideband bit for the completed word
//     ready_i      : consumer accepts data_o when valid_o && ready_i
//     data_o       : held word (stable while valid_o && !ready_i)
//     valid_o      : data_o holds an unaccepted word
//     side_o       : sideband bit belonging to data_o
//     overrun_o    : one-cycle pulse, a completed word was dropped
// -----------------------------------------------------------------------------
module deser_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  side_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  side_o,
  output logic                  overrun_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  side_q;
  logic                  overrun_q;

  // The register can take a new word if it is empty or being drained now.
  logic can_load;
  assign can_load = !valid_q || ready_i;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; the data register is reset too because
  // dout must read 0 out of reset, not just be "don't care" until valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      side_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Completion into a full, stalled register drops the new word and its
      // sideband together; the held word is untouched.
      overrun_q <= load_i && !can_load;

      if (load_i && can_load) begin
        data_q  <= data_i;
        side_q  <= side_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign side_o    = side_q;
  assign overrun_o = overrun_q;

endmodule : deser_out_reg

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//   Serial-in, parallel-out receiver for an LSB-first bitstream. One bit is
//   sampled per cycle with din_en high; every DATA_WIDTH bits a word is
//   presented on a valid/ready holding register. A word completing while the
//   previous one is still unaccepted is dropped and flagged on overrun.
//
//   Optional feature (macro SERIAL_DESERIALIZER_PARITY_EN):
//     each frame carries one trailing even-parity bit; the word completes on
//     that bit and parity_err reports XOR(data, parity). Without the macro
//     parity_err is constant 0.
//
//   Ports:
//     clk        : clock, rising edge
//     resetn     : asynchronous active-low reset
//     din        : serial data bit, word LSB first
//     din_en     : din is valid this cycle
//     sync_clr   : synchronous flush of partial word and bit counter
//     dout       : assembled word
//     dout_valid : dout holds an unaccepted word
//     dout_ready : consumer accepts dout when dout_valid && dout_ready
//     overrun    : one-cycle pulse, a completed word was dropped
//     parity_err : parity result for the word on dout
// -----------------------------------------------------------------------------
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_en,
  input  logic                  sync_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int            CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shifter_q;
  logic [CW-1:0]         bit_cnt_q;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  last_bit;
  logic                  complete;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_par;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    shifted  = {din, shifter_q[DATA_WIDTH-1:1]};
    last_bit = (bit_cnt_q == LAST_IDX);
    complete = 1'b0;
    word     = shifted;
    word_par = 1'b0;
    // sync_clr wins over din_en, so a flushed cycle never completes a word.
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    if (din_en && !sync_clr && state_q == PARITY) begin
      // The data bits are already fully shifted in; din is the parity bit.
      complete = 1'b1;
      word     = shifter_q;
      word_par = (^shifter_q) ^ din;
    end
`else
    if (din_en && !sync_clr && state_q == COLLECT && last_bit) begin
      complete = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= COLLECT;
      shifter_q <= '0;
      bit_cnt_q <= '0;
    end else if (sync_clr) begin
      state_q   <= COLLECT;
      shifter_q <= '0;
      bit_cnt_q <= '0;
    end else if (din_en) begin
      case (state_q)
        COLLECT: begin
          shifter_q <= shifted;
          bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          if (last_bit) begin
            state_q <= PARITY;
          end
`endif
        end
        // PARITY: the parity bit is consumed without touching the shifter.
        default: state_q <= COLLECT;
      endcase
    end
  end

  deser_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .resetn    (resetn),
    .load_i    (complete),
    .data_i    (word),
    .side_i    (word_par),
    .ready_i   (dout_ready),
    .data_o    (dout),
    .valid_o   (dout_valid),
    .side_o    (parity_err),
    .overrun_o (overrun)
  );

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//   Scoreboard bench: a bit-queue reference model predicts completed words,
//   holding-register occupancy and overrun pulses; a monitor compares every
//   accepted word and the per-cycle flags against those predictions.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

  localparam int W = 16;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         din = 1'b0;
  logic         din_en = 1'b0;
  logic         sync_clr = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         parity_err;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t sb[$];
  logic bits[$];
  logic exp_full = 1'b0;
  logic exp_ovr  = 1'b0;

  serial_deserializer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_en     (din_en),
    .sync_clr   (sync_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects received bits; a frame is complete once FRAME
  // bits are queued. The word is the first W bits, LSB first; parity error
  // is the XOR of every bit in the frame.
  always @(posedge clk or negedge resetn) begin
    exp_t item;
    if (!resetn) begin
      bits.delete();
      sb.delete();
      exp_full = 1'b0;
      exp_ovr  = 1'b0;
    end else begin
      bit done;
      done    = 1'b0;
      exp_ovr = 1'b0;
      if (sync_clr) begin
        bits.delete();
      end else if (din_en) begin
        bits.push_back(din);
        if (bits.size() == FRAME) begin
          item.data = '0;
          item.perr = 1'b0;
          for (int i = 0; i < W; i++) item.data[i] = bits[i];
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          for (int i = 0; i < FRAME; i++) item.perr = item.perr ^ bits[i];
`endif
          bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!exp_full || dout_ready) begin
          sb.push_back(item);
          exp_full = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_full && dout_ready) begin
        exp_full = 1'b0;
      end
    end
  end

  // Monitor: away from the active edge, check flags and pop accepted words.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      check("dout_valid", 32'(dout_valid), 32'(exp_full));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: accepted dout 0x%0h with no word expected", dout);
        end else begin
          e = sb.pop_front();
          check("dout", 32'(dout), 32'(e.data));
          check("parity_err", 32'(parity_err), 32'(e.perr));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send_bits(input logic [31:0] f, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      din    = f[i];
      din_en = 1'b1;
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
      tick();
      din    = 1'b0;
      din_en = 1'b0;
      if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  // Frame for a word: data bits, plus an even-parity bit (optionally
  // inverted) when parity framing is built in.
  function automatic logic [31:0] mk_frame(input logic [W-1:0] d, input logic flip);
    logic [31:0] f;
    f = 32'(d);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    f[W] = (^d) ^ flip;
`else
    if (flip) f = 32'(d);
`endif
    return f;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;

    // Reset state
    #3;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Back-to-back bits, consumer always ready
    dout_ready = 1'b1;
    send_bits(mk_frame(16'hA5C3, 1'b0), FRAME, 0);
    check("a5c3_dout", 32'(dout), 32'hA5C3);
    check("a5c3_valid", 32'(dout_valid), 32'h1);
    tick();
    check("a5c3_drained", 32'(dout_valid), 32'h0);

    // Same word with random gaps
    send_bits(mk_frame(16'hA5C3, 1'b0), FRAME, 3);
    idle(3);

    // Overrun: consumer stalled
    dout_ready = 1'b0;
    send_bits(mk_frame(16'h1234, 1'b0), FRAME, 0);
    send_bits(mk_frame(16'hFFFF, 1'b0), FRAME, 0);
    check("ovr_pulse", 32'(overrun), 32'h1);
    check("ovr_hold", 32'(dout), 32'h1234);
    tick();
    check("ovr_one_cycle", 32'(overrun), 32'h0);
    dout_ready = 1'b1;
    tick();
    check("ovr_cleared", 32'(dout_valid), 32'h0);

    // Accept and completion in the same cycle
    dout_ready = 1'b0;
    send_bits(mk_frame(16'h0001, 1'b0), FRAME, 0);
    tick();
    f = mk_frame(16'h8000, 1'b0);
    send_bits(f, FRAME - 1, 0);
    dout_ready = 1'b1;
    send_bits(f >> (FRAME - 1), 1, 0);
    check("swap_dout", 32'(dout), 32'h8000);
    check("swap_valid", 32'(dout_valid), 32'h1);
    check("swap_no_ovr", 32'(overrun), 32'h0);
    tick();

    // sync_clr flushes a partial word, winning over din_en
    send_bits(32'h5A5A, 7, 0);
    din      = 1'b1;
    din_en   = 1'b1;
    sync_clr = 1'b1;
    tick();
    din      = 1'b0;
    din_en   = 1'b0;
    sync_clr = 1'b0;
    send_bits(mk_frame(16'h00FF, 1'b0), FRAME, 0);
    check("clr_dout", 32'(dout), 32'h00FF);
    tick();

    // Asynchronous reset mid-word
    send_bits(mk_frame(16'hFFFF, 1'b0), 5, 0);
    dout_ready = 1'b0;
    send_bits(mk_frame(16'hFFFF, 1'b0), 5, 0);
    resetn = 1'b0;
    #1;
    check("amid_dout", 32'(dout), 32'h0);
    check("amid_valid", 32'(dout_valid), 32'h0);
    check("amid_overrun", 32'(overrun), 32'h0);
    check("amid_perr", 32'(parity_err), 32'h0);
    tick();
    resetn = 1'b1;
    dout_ready = 1'b1;
    tick();
    send_bits(mk_frame(16'h0F0F, 1'b0), FRAME, 0);
    check("post_rst_dout", 32'(dout), 32'h0F0F);
    tick();

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_bits(32'h0_0003, FRAME, 0);
    check("par_ok_dout", 32'(dout), 32'h0003);
    check("par_ok_err", 32'(parity_err), 32'h0);
    tick();
    send_bits(32'h0_0007, FRAME, 0);
    check("par_bad_dout", 32'(dout), 32'h0007);
    check("par_bad_err", 32'(parity_err), 32'h1);
    tick();
`endif

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send_bits(mk_frame(W'($urandom), 1'($urandom_range(0, 1))), FRAME, 3);
    end
    rand_ready = 1'b0;
    dout_ready = 1'b1;
    idle(4);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_deserializer
